hilo_unit: RTL

- Sits directly downstream of the 32x32 unsigned multiplier (64-bit product `z`).
- Sequences MULTU: registers operands onto the multiplier inputs, waits a fixed settle latency, then captures the 64-bit product into the architectural HI/LO registers.
- Also services MTHI/MTLO/MFHI/MFLO for the CPU.
- Drives a busy stall so the pipeline never reads HI/LO before the product lands.

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_lat_cnt.sv | 31 +++
 rtl/hilo_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op encoding, FSM state type and counter width for the
// HI/LO unit and its latency counter.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULTU = 3'd1,
    OP_MTHI  = 3'd2,
    OP_MTLO  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/hilo_lat_cnt.sv
// hilo_lat_cnt: loadable down-counter that times the multiplier settle
// latency; 'last' flags the cycle whose closing edge lands the product.
module hilo_lat_cnt
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // Load on a new MULTU, otherwise count down while the unit is busy.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would make read order inside the block matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: sequences MULTU through an external 32x32 multiplier and owns
// the architectural HI/LO registers plus MTHI/MTLO/MFHI/MFLO access.
// Optional build macro HILO_FWD_EN: accept a request in the last busy cycle
// and forward the landing product to it.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [63:0] prod,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        mul_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state;
  op_e         op_code;
  logic        cnt_last;
  logic        in_last;
  logic        accept;
  logic        mult_go;
  logic [31:0] hi_cur;
  logic [31:0] lo_cur;

  assign op_code = op_e'(op);
  assign in_last = (state == BUSY) && cnt_last;

`ifdef HILO_FWD_EN
  // The final busy cycle is open to a new request; reads see the product
  // that is landing on this same edge.
  assign busy   = (state == BUSY) && !cnt_last;
  assign hi_cur = in_last ? prod[63:32] : hi;
  assign lo_cur = in_last ? prod[31:0]  : lo;
`else
  assign busy   = (state == BUSY);
  assign hi_cur = hi;
  assign lo_cur = lo;
`endif

  assign accept  = op_valid && !busy;
  assign mult_go = accept && (op_code == OP_MULTU);

  hilo_lat_cnt u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mult_go),
    .load_val (CNT_W'(MUL_LATENCY)),
    .dec      (state == BUSY),
    .last     (cnt_last)
  );

  // FSM plus HI/LO, operand and read-port registers; a landing product is
  // written first so an accepted op on the same edge overrides it.
  // NOTE: every register here, HI/LO included, is cleared by reset; an
  // abandoned multiply must leave HI/LO at zero, not at stale contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mul_a    <= '0;
      mul_b    <= '0;
      hi       <= '0;
      lo       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      mul_done <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      mul_done <= 1'b0;
      if (in_last) begin
        hi       <= prod[63:32];
        lo       <= prod[31:0];
        mul_done <= 1'b1;
        state    <= IDLE;
      end
      if (accept) begin
        case (op_code)
          OP_MULTU: begin
            mul_a <= rs_data;
            mul_b <= rt_data;
            state <= BUSY;
          end
          OP_MTHI: hi <= rs_data;
          OP_MTLO: lo <= rs_data;
          OP_MFHI: begin
            rd_data  <= hi_cur;
            rd_valid <= 1'b1;
          end
          OP_MFLO: begin
            rd_data  <= lo_cur;
            rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
